// File: rtl/led_pattern_pkg.sv
// Shared types and register map for the LED pattern peripheral.
package led_pattern_pkg;

    typedef enum logic [1:0] {
        STATIC = 2'd0,
        BLINK  = 2'd1,
        ROTATE = 2'd2,
        BOUNCE = 2'd3
    } mode_t;

    typedef enum logic {
        LEFT  = 1'b0,
        RIGHT = 1'b1
    } dir_t;

    localparam logic ADDR_CTRL   = 1'b0;
    localparam logic ADDR_PERIOD = 1'b1;

    localparam int PAT_LSB  = 0;
    localparam int MODE_LSB = 8;
    localparam int EN_BIT   = 10;

    localparam logic PHASE_ON = 1'b1;

endpackage

// File: rtl/led_prescaler.sv
// Reloading down-counter that paces the LED animation.
module led_prescaler #(
    parameter int                    PERIOD_W   = 24,
    parameter logic [PERIOD_W-1:0]   PERIOD_RST = 24'd4_999_999
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [PERIOD_W-1:0] period,
    input  logic                restart,
    input  logic                enable,
    output logic                step
);

    logic [PERIOD_W-1:0] cnt_q;
    logic [PERIOD_W-1:0] cnt_d;

    // A restart always beats a pending step.
    assign step = enable && (cnt_q == '0) && !restart;

    always_comb begin
        cnt_d = cnt_q;
        if (restart) begin
            cnt_d = period;
        end else if (enable) begin
            if (cnt_q == '0) begin
                cnt_d = period;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= PERIOD_RST;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/led_pattern_ctrl.sv
// Avalon-MM LED peripheral: register file, animation state and read mux.
module led_pattern_ctrl
    import led_pattern_pkg::*;
#(
    parameter int                  LED_W      = 8,
    parameter int                  PERIOD_W   = 24,
    parameter logic [PERIOD_W-1:0] PERIOD_RST = 24'd4_999_999
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             avs_s0_address,
    input  logic             avs_s0_read,
    output logic [31:0]      avs_s0_readdata,
    input  logic             avs_s0_write,
    input  logic [31:0]      avs_s0_writedata,
    output logic [LED_W-1:0] leds
);

    logic [LED_W-1:0]    pattern_q, pattern_d;
    mode_t               mode_q, mode_d;
    logic                en_q, en_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic [LED_W-1:0]    work_q, work_d;
    logic                phase_q, phase_d;
    dir_t                dir_q, dir_d;
    logic [LED_W-1:0]    leds_q, leds_d;
    logic [31:0]         rdata_q, rdata_d;

    logic        wr_ctrl;
    logic        wr_period;
    logic        step;
    logic        edge_hold;
    logic [31:0] ctrl_rd;
    logic [31:0] period_rd;
    logic        wd_unused;

    assign wd_unused = ^avs_s0_writedata[31:24];

    assign wr_ctrl   = avs_s0_write && (avs_s0_address == ADDR_CTRL);
    assign wr_period = avs_s0_write && (avs_s0_address == ADDR_PERIOD);

    // Both ends lit, or nothing lit, leaves bounce with nowhere to go.
    assign edge_hold = (work_q == '0) ||
                       (work_q[LED_W-1] && work_q[0]);

    led_prescaler #(
        .PERIOD_W   (PERIOD_W),
        .PERIOD_RST (PERIOD_RST)
    ) u_prescaler (
        .clk     (clk),
        .reset   (reset),
        .period  (period_d),
        .restart (avs_s0_write),
        .enable  (en_q),
        .step    (step)
    );

    always_comb begin
        ctrl_rd                     = '0;
        ctrl_rd[PAT_LSB +: LED_W]   = pattern_q;
        ctrl_rd[MODE_LSB +: 2]      = mode_q;
        ctrl_rd[EN_BIT]             = en_q;
        period_rd                   = '0;
        period_rd[PERIOD_W-1:0]     = period_q;
        period_rd[31:24]            = leds_q[7:0];
    end

    always_comb begin
        pattern_d = pattern_q;
        mode_d    = mode_q;
        en_d      = en_q;
        period_d  = period_q;
        work_d    = work_q;
        phase_d   = phase_q;
        dir_d     = dir_q;
        rdata_d   = rdata_q;

        if (avs_s0_read) begin
            rdata_d = (avs_s0_address == ADDR_CTRL) ? ctrl_rd : period_rd;
        end

        if (wr_period) begin
            period_d = avs_s0_writedata[PERIOD_W-1:0];
        end

        if (wr_ctrl) begin
            pattern_d = avs_s0_writedata[PAT_LSB +: LED_W];
            mode_d    = mode_t'(avs_s0_writedata[MODE_LSB +: 2]);
            en_d      = avs_s0_writedata[EN_BIT];
            work_d    = avs_s0_writedata[PAT_LSB +: LED_W];
            dir_d     = LEFT;
            phase_d   = PHASE_ON;
        end else if (step) begin
            unique case (mode_q)
                STATIC: work_d = pattern_q;
                BLINK:  phase_d = ~phase_q;
                ROTATE: work_d = {work_q[LED_W-2:0], work_q[LED_W-1]};
                BOUNCE: begin
                    if (!edge_hold) begin
                        if (dir_q == LEFT) begin
                            if (work_q[LED_W-1]) begin
                                dir_d  = RIGHT;
                                work_d = work_q >> 1;
                            end else begin
                                work_d = work_q << 1;
                            end
                        end else begin
                            if (work_q[0]) begin
                                dir_d  = LEFT;
                                work_d = work_q << 1;
                            end else begin
                                work_d = work_q >> 1;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end

        leds_d = work_d;
        if (mode_d == BLINK && phase_d != PHASE_ON) begin
            leds_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pattern_q <= '0;
            mode_q    <= STATIC;
            en_q      <= 1'b0;
            period_q  <= PERIOD_RST;
            work_q    <= '0;
            phase_q   <= PHASE_ON;
            dir_q     <= LEFT;
            leds_q    <= '0;
            rdata_q   <= '0;
        end else begin
            pattern_q <= pattern_d;
            mode_q    <= mode_d;
            en_q      <= en_d;
            period_q  <= period_d;
            work_q    <= work_d;
            phase_q   <= phase_d;
            dir_q     <= dir_d;
            leds_q    <= leds_d;
            rdata_q   <= rdata_d;
        end
    end

    assign leds            = leds_q;
    assign avs_s0_readdata = rdata_q;

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Scoreboard bench for led_pattern_ctrl against a cycle-level reference model.
module tb_led_pattern_ctrl;

    localparam int PRST = 4_999_999;

    logic        clk;
    logic        reset;
    logic        avs_s0_address;
    logic        avs_s0_read;
    logic [31:0] avs_s0_readdata;
    logic        avs_s0_write;
    logic [31:0] avs_s0_writedata;
    logic [7:0]  leds;

    led_pattern_ctrl dut (
        .clk              (clk),
        .reset            (reset),
        .avs_s0_address   (avs_s0_address),
        .avs_s0_read      (avs_s0_read),
        .avs_s0_readdata  (avs_s0_readdata),
        .avs_s0_write     (avs_s0_write),
        .avs_s0_writedata (avs_s0_writedata),
        .leds             (leds)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  leds;
        bit          rd_v;
        logic [31:0] rd;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state, kept as plain integers
    int         m_pat, m_mode, m_work, m_period;
    bit         m_en, m_on, m_right;
    bit [31:0]  m_rd;
    longint     edge_n = 0;
    longint     next_step_edge = 0;

    function automatic int m_out();
        if (m_mode == 1 && !m_on) return 0;
        return m_work;
    endfunction

    task automatic m_step();
        case (m_mode)
            0: m_work = m_pat;
            1: m_on = !m_on;
            2: m_work = (m_work * 2) % 256 + m_work / 128;
            default: begin
                if (m_work == 0 || (m_work >= 128 && m_work % 2 == 1)) begin
                end else if (!m_right) begin
                    if (m_work >= 128) begin
                        m_right = 1;
                        m_work  = m_work / 2;
                    end else begin
                        m_work = (m_work * 2) % 256;
                    end
                end else begin
                    if (m_work % 2 == 1) begin
                        m_right = 0;
                        m_work  = (m_work * 2) % 256;
                    end else begin
                        m_work = m_work / 2;
                    end
                end
            end
        endcase
    endtask

    task automatic model_edge(bit rst, bit rd, bit wr, bit addr, bit [31:0] wd);
        exp_t e;
        edge_n++;
        if (rst) begin
            m_pat = 0; m_mode = 0; m_en = 0; m_period = PRST;
            m_work = 0; m_on = 1; m_right = 0; m_rd = 0;
            next_step_edge = edge_n + PRST + 1;
        end else begin
            if (rd) begin
                if (addr) m_rd = 32'(m_out()) * 32'h0100_0000 + 32'(m_period);
                else      m_rd = 32'(m_en) * 1024 + 32'(m_mode) * 256 + 32'(m_pat);
            end
            if (wr) begin
                if (!addr) begin
                    m_pat  = int'(wd[7:0]);
                    m_mode = int'(wd[9:8]);
                    m_en   = wd[10];
                    m_work = m_pat;
                    m_on   = 1;
                    m_right = 0;
                end else begin
                    m_period = int'(wd[23:0]);
                end
                next_step_edge = edge_n + m_period + 1;
            end else if (m_en) begin
                if (edge_n == next_step_edge) begin
                    m_step();
                    next_step_edge = edge_n + m_period + 1;
                end
            end else begin
                next_step_edge++;
            end
        end
        e.leds = 8'(m_out());
        e.rd_v = rd;
        e.rd   = m_rd;
        exp_q.push_back(e);
    endtask

    task automatic tick(bit rst, bit rd, bit wr, bit addr, bit [31:0] wd);
        reset            = rst;
        avs_s0_read      = rd;
        avs_s0_write     = wr;
        avs_s0_address   = addr;
        avs_s0_writedata = wd;
        @(posedge clk);
        #1;
        model_edge(rst, rd, wr, addr, wd);
        @(negedge clk);
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) tick(0, 0, 0, 0, 32'h0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (leds !== e.leds) begin
                errors++;
                $display("FAIL leds t=%0t got=%02h exp=%02h", $time, leds, e.leds);
            end
            if (e.rd_v) begin
                checks++;
                if (avs_s0_readdata !== e.rd) begin
                    errors++;
                    $display("FAIL readdata t=%0t got=%08h exp=%08h",
                             $time, avs_s0_readdata, e.rd);
                end
            end
        end
    end

    initial begin
        int r;
        bit [31:0] wd;
        reset = 1; avs_s0_read = 0; avs_s0_write = 0;
        avs_s0_address = 0; avs_s0_writedata = 0;
        @(negedge clk);

        tick(1, 0, 0, 0, 0);
        tick(1, 0, 0, 0, 0);
        tick(0, 1, 0, 0, 0);
        tick(0, 1, 0, 1, 0);
        idle(1);
        checks++;
        if (avs_s0_readdata !== 32'h004C_4B3F) begin
            errors++;
            $display("FAIL period_rst got=%08h exp=%08h", avs_s0_readdata, 32'h004C_4B3F);
        end

        tick(0, 0, 1, 1, 32'd3);
        tick(0, 0, 1, 0, 32'h601);
        idle(40);

        tick(0, 0, 1, 1, 32'd0);
        tick(0, 0, 1, 0, 32'h701);
        idle(20);
        tick(0, 0, 1, 0, 32'h781);
        idle(5);

        tick(0, 0, 1, 1, 32'd1);
        tick(0, 0, 1, 0, 32'h5A5);
        idle(10);
        tick(0, 0, 1, 0, 32'h1A5);
        idle(6);

        tick(0, 0, 1, 1, 32'd0);
        tick(0, 0, 1, 0, 32'h601);
        idle(3);
        tick(0, 1, 1, 0, 32'h6F0);
        idle(2);
        tick(0, 1, 0, 0, 0);

        tick(0, 0, 1, 1, 32'd2);
        tick(0, 0, 1, 0, 32'h603);
        idle(7);
        tick(1, 1, 0, 1, 0);
        tick(0, 1, 0, 1, 0);

        for (int i = 0; i < 800; i++) begin
            r = $urandom_range(0, 99);
            wd = $urandom;
            if (r < 2) begin
                tick(1, $urandom_range(0, 1), 0, 1, 0);
            end else if (r < 14) begin
                tick(0, $urandom_range(0, 2) == 0, 1, 0, wd);
            end else if (r < 20) begin
                wd[23:0] = 24'($urandom_range(0, 6));
                tick(0, $urandom_range(0, 2) == 0, 1, 1, wd);
            end else begin
                tick(0, $urandom_range(0, 3) == 0, 0, 1'($urandom_range(0, 1)), wd);
            end
        end

        idle(1);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain left=%0d exp=0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/led_pattern_ctrl.md
# led_pattern_ctrl

Avalon-MM slave LED peripheral that sits directly downstream of the HPS lightweight bridge on the `Custom_leds_0_s0` port and drives the 8 board LEDs. Software writes a base pattern, an animation mode and a step period. The block then animates the LEDs autonomously: static, blink, rotate or bounce, advanced by an internal prescaler. Readback exposes the live LED state.

## Interface
Parameters:
- `LED_W`, 8, LED count; also the pattern width.
- `PERIOD_W`, 24, prescaler reload width.
- `PERIOD_RST`, 24'd4_999_999, PERIOD register reset value (10 Hz step at 50 MHz).

Ports:
- `clk`, in, 1, system clock; all logic is on this one clock.
- `reset`, in, 1, synchronous, active-high.
- `avs_s0_address`, in, 1, word address: 0 = CTRL, 1 = PERIOD.
- `avs_s0_read`, in, 1, read strobe.
- `avs_s0_readdata`, out, 32, registered read data.
- `avs_s0_write`, in, 1, write strobe.
- `avs_s0_writedata`, in, 32, write data.
- `leds`, out, `LED_W`, LED drive; 1 = lit.

## Operation
CTRL register (address 0), R/W:
- [7:0] `pattern`
- [9:8] `mode`: 0 STATIC, 1 BLINK, 2 ROTATE, 3 BOUNCE
- [10] `enable`
- [31:11] read as 0

PERIOD register (address 1):
- Write: [23:0] `period`.
- Read: {`leds`[7:0], `period`[23:0]}.

Writes:
- A write to CTRL loads the `work` register with `pattern`, sets `dir` to LEFT and `phase` to ON, and restarts the prescaler.
- A write to PERIOD restarts the prescaler with the new value.

Prescaler:
- Down-counter loaded with `period`; emits a one-cycle `step` when it is 0 and `enable` = 1, then reloads.
- A step therefore occurs every `period`+1 cycles; `period` = 0 steps every cycle.
- `enable` = 0 freezes both the counter and `work`.

On `step`, per mode:
- STATIC: `work` holds `pattern`.
- BLINK: `phase` toggles; `leds` = `phase`==ON ? `work` : 0.
- ROTATE: `work` rotates left by 1 (bit 7 wraps to bit 0).
- BOUNCE, `dir` FSM with states LEFT and RIGHT:
  - LEFT: if `work`[7], go to RIGHT and shift right logically; else shift left logically.
  - RIGHT: mirror of LEFT, testing `work`[0].
  - If `work`[7] and `work`[0] are both set, or `work` == 0, hold.
- Output: `leds` = `work`, except BLINK as above.

## Timing
- Reset values:
  - CTRL = 0, PERIOD = `PERIOD_RST`, `work` = 0, prescaler = `PERIOD_RST`
  - `dir` = LEFT, `phase` = ON
  - `leds` = 0, `avs_s0_readdata` = 0
- Read latency is fixed at 1. `avs_s0_readdata` is valid the cycle after `avs_s0_read` and holds until the next read. No waitrequest.
- Write takes effect at the clock edge where `avs_s0_write` = 1. `leds` reflects a CTRL write on the next cycle.
- Read and write to the same address in the same cycle: readdata returns the pre-write value.
- Write and `step` in the same cycle: the write wins and the step is discarded.
- The first step after a restart occurs `period`+1 cycles after the write edge.
- `leds` is registered, so it changes one cycle after the `step` cycle.
- Reset asserted mid-animation returns every state element to its reset value at the next edge. Any in-flight read returns 0.

## Structure
- Package `led_pattern_pkg`:
  - `mode_t` enum (STATIC/BLINK/ROTATE/BOUNCE)
  - `dir_t` enum (LEFT/RIGHT)
  - address constants `ADDR_CTRL`, `ADDR_PERIOD`
  - CTRL field positions (`PAT_LSB`, `MODE_LSB`, `EN_BIT`)
- Sub-module `led_prescaler`:
  - Inputs: `period`, `restart`, `enable`.
  - Output: `step`.
- Top level holds the register file, the `work`/`phase`/`dir` state and the read mux.

## Test plan
- Reset, then read both addresses: readdata 0x0000_0000 for CTRL, 0x004C_4B3F for PERIOD; `leds` = 0x00.
- PERIOD = 3, CTRL = 0x601 (ROTATE, en, 0x01): `leds` 0x01, then 0x02 four cycles later, 0x04 after eight; after 8 steps it wraps back to 0x01.
- PERIOD = 0, CTRL = 0x701 (BOUNCE): `leds` runs 01,02,…,80,40,…,01,02 one step per cycle. Pattern 0x81 holds at 0x81.
- PERIOD = 1, CTRL = 0x5A5 (BLINK): `leds` alternates 0xA5 and 0x00 every 2 cycles. Clearing `enable` freezes the current value.
- Rewrite CTRL in the same cycle as a step: no step applied; `leds` = new pattern. A same-cycle read of CTRL returns the old value.
- Assert `reset` mid-ROTATE: next cycle `leds` = 0 and PERIOD reads back the `PERIOD_RST` value.
